imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//   Boot sequencer for the pipelined RV32I core. Holds the core in reset and
//   accepts a stream of 32-bit program words over a valid/ready handshake.
//   Writes each word into instruction RAM as four big-endian bytes ([31:24] at
//   addr 4n). Releases core reset once loading completes and the hold time expires.
// PARAMETERS
//   ADDR_WIDTH  10   byte-address width of instruction RAM
//   MAX_WORDS   256  capacity in words; MAX_WORDS*4 <= 2**ADDR_WIDTH
//   RESET_HOLD  4    cycles core_reset stays high after last byte written (>=1)
// PORTS
//   clock         in   1   system clock, all logic on rising edge
//   reset         in   1   synchronous, active-high
//   start         in   1   1-cycle pulse: begin (re)load
//   word_valid    in   1   word_data/word_last valid
//   word_data     in   32  program word
//   word_last     in   1   marks final word of program
//   word_ready    out  1   loader accepts word this cycle
//   imem_we       out  1   instruction RAM byte write enable
//   imem_addr     out  ADDR_WIDTH  byte address
//   imem_wdata    out  8   byte data
//   core_reset    out  1   reset to core (active-high)
//   core_mem_en   out  1   memory enable to core
//   busy          out  1   high in ACCEPT/WRITE/HOLD
//   done          out  1   high in RUN
//   error         out  1   high in ERROR (overflow)
//   words_loaded  out  $clog2(MAX_WORDS+1)  words fully written this load
// BEHAVIOUR
// - Every output is registered, except word_ready, which decodes state only
//   and never depends on word_valid.
// - Reset values: IDLE, word_ready=0, imem_we=0, imem_addr=0, imem_wdata=0,
//   core_reset=1, core_mem_en=0, busy=0, done=0, error=0, words_loaded=0.
// - States: IDLE, ACCEPT, WRITE, HOLD, RUN, ERROR.
// - IDLE: core_reset=1. On start -> ACCEPT. Also clears words_loaded and the
//   word index.
// - ACCEPT: word_ready=1. Handshake when word_valid & word_ready. On handshake,
//   latch word_data/word_last, byte_idx=0 -> WRITE. Source may change data
//   after handshake.
// - WRITE: 4 consecutive cycles, imem_we=1.
//   - imem_addr = word_idx*4 + byte_idx.
//   - imem_wdata = byte_idx 0..3 -> [31:24],[23:16],[15:8],[7:0].
//   - On byte_idx 3: words_loaded/word_idx +1. Then if last -> HOLD; else if
//     word_idx+1 == MAX_WORDS -> ERROR; else -> ACCEPT.
// - Throughput: 5 cycles per word (1 accept + 4 writes); no overlap.
// - HOLD: core_reset=1, core_mem_en=1, counter runs RESET_HOLD cycles -> RUN.
// - RUN: core_reset=0, core_mem_en=1, done=1.
// - start handling:
//   - In RUN or ERROR: start -> ACCEPT with counters cleared; core_reset=1 and
//     core_mem_en=0 from the next edge.
//   - In ACCEPT/WRITE/HOLD: start is ignored.
// - ERROR: word_ready=0, imem_we=0, core_reset=1, error=1 sticky until start
//   or reset.
// - Reset mid-load: IDLE at next edge, imem_we drops. RAM bytes already
//   written are retained, not cleared.
// - Simultaneous reset and start: reset wins.
// - word_valid outside ACCEPT: ignored, no handshake.
// TESTING
// 1 reset; start; words 0x00300213, 0x07FF00B7 (last) ->
//   - byte writes 0..7 = 00 30 02 13 07 FF 00 B7, imem_we 8 cycles total;
//   - words_loaded=2; core_reset falls RESET_HOLD cycles after byte 7; done=1.
// 2 word_valid with gaps (valid low 3 cycles between words) ->
//   - no writes during gaps, addresses contiguous, no duplicated bytes.
// 3 MAX_WORDS=4, feed 5 words, none with last ->
//   - ERROR after 4th word: error=1, word_ready=0, core_reset=1;
//     - 5th word never accepted.
// 4 reset asserted during WRITE byte 2 ->
//   - next cycle imem_we=0, core_reset=1, IDLE;
//   - start reloads from addr 0.
// 5 in RUN, start then 1 word 0x00000013 (last) ->
//   - core_reset re-asserts next cycle, bytes to addr 0..3, words_loaded=1,
//     core released again.
// 6 start pulsed during ACCEPT and HOLD ->
//   - no effect on sequence, words_loaded, or release timing.

Source files
------------

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Boot sequencer for the pipelined RV32I core. While loading, the core is held
// in reset and program words arrive over a valid/ready handshake. Each accepted
// word is written into instruction RAM as four big-endian bytes (bits [31:24]
// land at byte address 4n). Once the word flagged as last has been written,
// core_reset is held for RESET_HOLD more cycles and then released.
//
// Parameters
//   ADDR_WIDTH  byte-address width of instruction RAM
//   MAX_WORDS   capacity in words (MAX_WORDS*4 must fit in 2**ADDR_WIDTH)
//   RESET_HOLD  cycles core_reset stays high after the last byte write (>= 1)
//
// Ports
//   clock         system clock, all logic on the rising edge
//   reset         synchronous, active-high
//   start         one-cycle pulse: begin (re)load from IDLE, RUN or ERROR
//   word_valid    word_data / word_last are valid
//   word_data     program word
//   word_last     marks the final word of the program
//   word_ready    loader accepts a word this cycle (decoded from state only)
//   imem_we       instruction RAM byte write enable
//   imem_addr     instruction RAM byte address
//   imem_wdata    instruction RAM byte data
//   core_reset    reset to the core (active-high)
//   core_mem_en   memory enable to the core
//   busy          high while accepting, writing or holding
//   done          high once the core is running
//   error         high after a capacity overflow, until start or reset
//   words_loaded  words fully written during the current load
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter  int ADDR_WIDTH = 10,
  parameter  int MAX_WORDS  = 256,
  parameter  int RESET_HOLD = 4,
  localparam int WL_W       = $clog2(MAX_WORDS + 1),
  localparam int HC_W       = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  word_valid,
  input  logic [31:0]           word_data,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [7:0]            imem_wdata,
  output logic                  core_reset,
  output logic                  core_mem_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WL_W-1:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                  state_reg;

  // Only the three lower bytes of the word need storing: the top byte goes
  // straight from word_data to imem_wdata on the handshake edge. The rest is
  // shifted up one byte per write so the next byte is always at [23:16].
  logic [23:0]             word_reg;
  logic                    last_reg;
  logic [1:0]              byte_idx_reg;
  logic [HC_W-1:0]         hold_cnt_reg;

  logic                    imem_we_reg;
  logic [ADDR_WIDTH-1:0]   imem_addr_reg;
  logic [7:0]              imem_wdata_reg;
  logic                    core_reset_reg;
  logic                    core_mem_en_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    error_reg;
  logic [WL_W-1:0]         words_loaded_reg;

  // The number of completed words doubles as the word index: the byte address
  // of the next word is simply words_loaded*4.
  logic [WL_W+1:0]         word_byte_base;
  assign word_byte_base = {words_loaded_reg, 2'b00};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      word_reg         <= '0;
      last_reg         <= 1'b0;
      byte_idx_reg     <= '0;
      hold_cnt_reg     <= '0;
      imem_we_reg      <= 1'b0;
      imem_addr_reg    <= '0;
      imem_wdata_reg   <= '0;
      core_reset_reg   <= 1'b1;
      core_mem_en_reg  <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
      words_loaded_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          words_loaded_reg <= '0;
          core_reset_reg   <= 1'b1;
          core_mem_en_reg  <= 1'b0;
          if (start) begin
            state_reg <= S_ACCEPT;
            busy_reg  <= 1'b1;
          end
        end

        S_ACCEPT: begin
          // word_ready is high for the whole of this state, so valid alone
          // completes the handshake.
          if (word_valid) begin
            word_reg       <= word_data[23:0];
            last_reg       <= word_last;
            byte_idx_reg   <= '0;
            imem_we_reg    <= 1'b1;
            imem_addr_reg  <= ADDR_WIDTH'(word_byte_base);
            imem_wdata_reg <= word_data[31:24];
            state_reg      <= S_WRITE;
          end
        end

        S_WRITE: begin
          // byte_idx_reg names the byte currently on the RAM port.
          if (byte_idx_reg != 2'd3) begin
            byte_idx_reg   <= byte_idx_reg + 2'd1;
            imem_addr_reg  <= imem_addr_reg + ADDR_WIDTH'(1);
            imem_wdata_reg <= word_reg[23:16];
            word_reg       <= {word_reg[15:0], 8'h00};
          end else begin
            imem_we_reg      <= 1'b0;
            words_loaded_reg <= words_loaded_reg + WL_W'(1);
            if (last_reg) begin
              // A last flag on the word that fills the RAM still counts as a
              // clean finish, so it is checked before capacity.
              state_reg       <= S_HOLD;
              hold_cnt_reg    <= '0;
              core_mem_en_reg <= 1'b1;
            end else if (words_loaded_reg + WL_W'(1) == WL_W'(MAX_WORDS)) begin
              state_reg <= S_ERROR;
              busy_reg  <= 1'b0;
              error_reg <= 1'b1;
            end else begin
              state_reg <= S_ACCEPT;
            end
          end
        end

        S_HOLD: begin
          if (hold_cnt_reg == HC_W'(RESET_HOLD - 1)) begin
            state_reg      <= S_RUN;
            core_reset_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HC_W'(1);
          end
        end

        S_RUN: begin
          if (start) begin
            state_reg        <= S_ACCEPT;
            words_loaded_reg <= '0;
            core_reset_reg   <= 1'b1;
            core_mem_en_reg  <= 1'b0;
            done_reg         <= 1'b0;
            busy_reg         <= 1'b1;
          end
        end

        S_ERROR: begin
          if (start) begin
            state_reg        <= S_ACCEPT;
            words_loaded_reg <= '0;
            error_reg        <= 1'b0;
            busy_reg         <= 1'b1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Decoded from state only so the source may wait on ready before raising
  // valid without creating a combinational loop.
  assign word_ready   = (state_reg == S_ACCEPT);

  assign imem_we      = imem_we_reg;
  assign imem_addr    = imem_addr_reg;
  assign imem_wdata   = imem_wdata_reg;
  assign core_reset   = core_reset_reg;
  assign core_mem_en  = core_mem_en_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign error        = error_reg;
  assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Directed sequence with random program words and gaps. The expected RAM write
// stream for each load is derived from the list of words sent: word i, byte k
// goes to address 4*i+k with data (word >> (24-8k)). A monitor records every
// cycle in which imem_we is high and the stream is compared after each load.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

  localparam int AW  = 5;
  localparam int MW  = 4;
  localparam int RH  = 3;
  localparam int WLW = $clog2(MW + 1);

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic           word_valid;
  logic [31:0]    word_data;
  logic           word_last;
  logic           word_ready;
  logic           imem_we;
  logic [AW-1:0]  imem_addr;
  logic [7:0]     imem_wdata;
  logic           core_reset;
  logic           core_mem_en;
  logic           busy;
  logic           done;
  logic           error;
  logic [WLW-1:0] words_loaded;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_we_cyc = 0;

  logic [15:0] wr_q[$];       // {3'b0, addr, data} per observed write
  logic [31:0] exp_words[$];  // words sent in the current load

  imem_boot_loader #(
    .ADDR_WIDTH (AW),
    .MAX_WORDS  (MW),
    .RESET_HOLD (RH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_last    (word_last),
    .word_ready   (word_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .core_mem_en  (core_mem_en),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wr_q.push_back({3'b000, imem_addr, imem_wdata});
      last_we_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Called and returns at a falling edge. On acceptance it returns in the
  // cycle where byte 0 of the word is on the RAM port.
  task automatic send_word(input logic [31:0] d, input logic l, input int gap,
                           input int budget, output bit acc);
    word_valid = 1'b0;
    repeat (gap) @(negedge clock);
    word_valid = 1'b1;
    word_data  = d;
    word_last  = l;
    acc = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (word_ready === 1'b1) begin
        acc = 1'b1;
        @(posedge clock);
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    word_valid = 1'b0;
    word_data  = $urandom;
    word_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_release(input string tag);
    int rel;
    rel = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (core_reset === 1'b0) begin
        rel = cyc;
        break;
      end
    end
    chk({tag, "_released"}, 32'(rel >= 0), 32'd1);
    chk({tag, "_hold_time"}, rel - last_we_cyc, RH + 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_mem_en"}, core_mem_en, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic check_load(input string tag);
    int n;
    logic [31:0] got;
    n = exp_words.size();
    chk({tag, "_nwrites"}, wr_q.size(), 4 * n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        got = (4 * i + k < wr_q.size()) ? 32'(wr_q[4 * i + k]) : 32'hDEAD0000;
        chk($sformatf("%s_byte%0d", tag, 4 * i + k), got,
            {16'h0, 3'b000, 5'(4 * i + k), 8'(exp_words[i] >> (24 - 8 * k))});
      end
    end
    chk({tag, "_words_loaded"}, words_loaded, n);
  endtask

  initial begin
    bit acc;
    int n;
    int gap;
    logic [31:0] w;

    reset      = 1'b1;
    start      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    word_last  = 1'b0;
    repeat (3) @(negedge clock);

    chk("rst_word_ready", word_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_core_mem_en", core_mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words_loaded", words_loaded, 0);

    reset = 1'b0;
    @(negedge clock);
    chk("idle_ready", word_ready, 0);
    chk("idle_core_reset", core_reset, 1);

    // Two-word program from the example.
    wr_q.delete();
    exp_words.delete();
    exp_words.push_back(32'h00300213);
    exp_words.push_back(32'h07FF00B7);
    pulse_start();
    chk("t1_ready", word_ready, 1);
    chk("t1_busy", busy, 1);
    send_word(exp_words[0], 1'b0, 0, 20, acc);
    chk("t1_acc0", acc, 1);
    send_word(exp_words[1], 1'b1, 0, 20, acc);
    chk("t1_acc1", acc, 1);
    wait_release("t1");
    check_load("t1");

    // Reloads from RUN with random words and gaps; the first fills the RAM
    // exactly with last on the final word and uses 3-cycle gaps.
    for (int it = 0; it < 3; it++) begin
      n = (it == 0) ? MW : int'($urandom_range(1, MW));
      wr_q.delete();
      exp_words.delete();
      for (int j = 0; j < n; j++) exp_words.push_back($urandom);
      pulse_start();
      chk($sformatf("t2_%0d_core_reset", it), core_reset, 1);
      chk($sformatf("t2_%0d_mem_en", it), core_mem_en, 0);
      chk($sformatf("t2_%0d_done", it), done, 0);
      chk($sformatf("t2_%0d_wl_clr", it), words_loaded, 0);
      for (int j = 0; j < n; j++) begin
        gap = (it == 0) ? 3 : int'($urandom_range(0, 3));
        send_word(exp_words[j], 1'(j == n - 1), gap, 30, acc);
        chk($sformatf("t2_%0d_acc%0d", it, j), acc, 1);
      end
      wait_release($sformatf("t2_%0d", it));
      check_load($sformatf("t2_%0d", it));
    end

    // Reload from RUN with a single NOP.
    wr_q.delete();
    exp_words.delete();
    exp_words.push_back(32'h00000013);
    pulse_start();
    chk("t5_core_reset", core_reset, 1);
    send_word(exp_words[0], 1'b1, 0, 20, acc);
    chk("t5_acc", acc, 1);
    wait_release("t5");
    check_load("t5");

    // start pulses in ACCEPT and HOLD must be ignored.
    wr_q.delete();
    exp_words.delete();
    exp_words.push_back($urandom);
    exp_words.push_back($urandom);
    pulse_start();
    pulse_start();
    chk("t6_ready", word_ready, 1);
    chk("t6_wl", words_loaded, 0);
    send_word(exp_words[0], 1'b0, 0, 20, acc);
    chk("t6_acc0", acc, 1);
    send_word(exp_words[1], 1'b1, 0, 20, acc);
    chk("t6_acc1", acc, 1);
    repeat (4) @(negedge clock);
    chk("t6_hold_core_reset", core_reset, 1);
    chk("t6_hold_mem_en", core_mem_en, 1);
    chk("t6_hold_busy", busy, 1);
    pulse_start();
    wait_release("t6");
    check_load("t6");

    // Overflow: MW words without last, then one more that must be refused.
    wr_q.delete();
    exp_words.delete();
    for (int j = 0; j < MW; j++) exp_words.push_back($urandom);
    pulse_start();
    for (int j = 0; j < MW; j++) begin
      send_word(exp_words[j], 1'b0, 0, 20, acc);
      chk($sformatf("t3_acc%0d", j), acc, 1);
    end
    send_word($urandom, 1'b0, 0, 12, acc);
    chk("t3_fifth_refused", acc, 0);
    chk("t3_error", error, 1);
    chk("t3_ready", word_ready, 0);
    chk("t3_core_reset", core_reset, 1);
    chk("t3_busy", busy, 0);
    chk("t3_done", done, 0);
    check_load("t3");
    pulse_start();
    chk("t3_error_clr", error, 0);
    chk("t3_ready_again", word_ready, 1);
    chk("t3_wl_clr", words_loaded, 0);

    // Reset during the write of byte 2.
    wr_q.delete();
    w = $urandom;
    send_word(w, 1'b1, 0, 20, acc);
    chk("t4_acc", acc, 1);
    repeat (2) @(negedge clock);
    chk("t4_b2_we", imem_we, 1);
    chk("t4_b2_addr", imem_addr, 2);
    chk("t4_b2_data", imem_wdata, 8'(w >> 8));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t4_we_drop", imem_we, 0);
    chk("t4_core_reset", core_reset, 1);
    chk("t4_idle_ready", word_ready, 0);
    chk("t4_busy", busy, 0);
    chk("t4_wl", words_loaded, 0);
    chk("t4_partial_writes", wr_q.size(), 3);
    wr_q.delete();
    exp_words.delete();
    exp_words.push_back($urandom);
    pulse_start();
    send_word(exp_words[0], 1'b1, 0, 20, acc);
    chk("t4_reload_acc", acc, 1);
    wait_release("t4");
    check_load("t4");

    // Reset and start together in RUN: reset wins.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    chk("rs_ready", word_ready, 0);
    chk("rs_done", done, 0);
    chk("rs_core_reset", core_reset, 1);
    @(negedge clock);
    chk("rs_stay_idle", word_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
